// File: rtl/chess_cursor_ctrl.sv
// rtl/chess_cursor_ctrl.sv - chess board cursor and move-request controller
// Define CHESS_CURSOR_WRAP_EN for modulo-8 cursor wrap; default saturates at 0 and 7.
module chess_cursor_ctrl #(
  parameter logic [2:0] CURSOR_X0 = 3'd4,
  parameter logic [2:0] CURSOR_Y0 = 3'd0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BtnL_pulse,
  input  logic       BtnR_pulse,
  input  logic       BtnU_pulse,
  input  logic       BtnD_pulse,
  input  logic       BtnC_pulse,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       src_valid,
  output logic       move_valid,
  input  logic       move_ready,
  input  logic       move_legal,
  output logic [5:0] move_src,
  output logic [5:0] move_dst,
  output logic       turn
);

  typedef enum logic [1:0] {SEL_SRC, SEL_DST, REQ} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic       r_src_valid, w_src_valid_nxt;
  logic       r_move_valid, w_move_valid_nxt;
  logic [5:0] r_move_src, w_move_src_nxt;
  logic [5:0] r_move_dst, w_move_dst_nxt;
  logic       r_turn, w_turn_nxt;
  logic [5:0] w_cur;

  // Opposing pulses in the same cycle cancel each other.
  function automatic logic [2:0] axis_step(input logic [2:0] v, input logic inc, input logic dec);
    logic [2:0] res;
    res = v;
`ifdef CHESS_CURSOR_WRAP_EN
    if (inc && !dec) res = v + 3'd1;
    else if (dec && !inc) res = v - 3'd1;
`else
    if (inc && !dec && v != 3'd7) res = v + 3'd1;
    else if (dec && !inc && v != 3'd0) res = v - 3'd1;
`endif
    return res;
  endfunction

  assign w_cur = {r_y, r_x};

  always_comb begin
    w_state_nxt      = r_state;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_src_valid_nxt  = r_src_valid;
    w_move_valid_nxt = r_move_valid;
    w_move_src_nxt   = r_move_src;
    w_move_dst_nxt   = r_move_dst;
    w_turn_nxt       = r_turn;
    case (r_state)
      SEL_SRC: begin
        w_x_nxt = axis_step(r_x, BtnR_pulse, BtnL_pulse);
        w_y_nxt = axis_step(r_y, BtnU_pulse, BtnD_pulse);
        if (BtnC_pulse) begin
          w_move_src_nxt  = w_cur;
          w_src_valid_nxt = 1'b1;
          w_state_nxt     = SEL_DST;
        end
      end
      SEL_DST: begin
        w_x_nxt = axis_step(r_x, BtnR_pulse, BtnL_pulse);
        w_y_nxt = axis_step(r_y, BtnU_pulse, BtnD_pulse);
        if (BtnC_pulse) begin
          if (w_cur == r_move_src) begin
            w_src_valid_nxt = 1'b0;
            w_state_nxt     = SEL_SRC;
          end else begin
            w_move_dst_nxt   = w_cur;
            w_move_valid_nxt = 1'b1;
            w_state_nxt      = REQ;
          end
        end
      end
      REQ: begin
        if (r_move_valid && move_ready) begin
          w_move_valid_nxt = 1'b0;
          w_src_valid_nxt  = 1'b0;
          w_turn_nxt       = r_turn ^ move_legal;
          w_state_nxt      = SEL_SRC;
        end
      end
      default: w_state_nxt = SEL_SRC;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= SEL_SRC;
      r_x          <= CURSOR_X0;
      r_y          <= CURSOR_Y0;
      r_src_valid  <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_src   <= 6'd0;
      r_move_dst   <= 6'd0;
      r_turn       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_src_valid  <= w_src_valid_nxt;
      r_move_valid <= w_move_valid_nxt;
      r_move_src   <= w_move_src_nxt;
      r_move_dst   <= w_move_dst_nxt;
      r_turn       <= w_turn_nxt;
    end
  end

  assign cursor_x   = r_x;
  assign cursor_y   = r_y;
  assign src_valid  = r_src_valid;
  assign move_valid = r_move_valid;
  assign move_src   = r_move_src;
  assign move_dst   = r_move_dst;
  assign turn       = r_turn;

endmodule
